// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the transmit frame sequencer.
package tx_ctrl_pkg;

  localparam int BITCNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    PAY   = 3'd2,
    TAIL  = 3'd3,
    DRAIN = 3'd4,
    GAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_PRE  = 2'd1,
    SEL_PRBS = 2'd2
  } bit_sel_t;

  // Index of the final bit of a segment of 'len' bits, in bit-counter width.
  function automatic logic [BITCNT_W-1:0] last_idx(input int len);
    return BITCNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/tx_strobe_gen.sv
// Prescaler producing symbol-rate and bit-rate clock-enable strobes.
// sym_stb fires once every DIV cycles; bit_stb fires on every second sym_stb.
module tx_strobe_gen #(
  parameter int DIV = 4
) (
  input  logic sys_clk,
  input  logic reset,
  output logic sym_stb,
  output logic bit_stb
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          tog;

  // Free-running 0..DIV-1 counter; the toggle flips on every symbol strobe.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt <= '0;
      tog <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      tog <= ~tog;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sym_stb = (cnt == CNT_MAX);
  assign bit_stb = sym_stb & tog;

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer for the transmit chain: preamble, PRBS payload, encoder
// flush tail, pipeline drain and inter-frame gap, all paced by bit_stb.
module tx_frame_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int          DIV        = 4,
  parameter int          PRE_LEN    = 16,
  parameter logic [15:0] PRE_WORD   = 16'hF35A,
  parameter int          PAY_LEN    = 64,
  parameter int          TAIL_LEN   = 2,
  parameter int          DRAIN_LEN  = 2,
  parameter int          GAP_LEN    = 8,
  parameter int          ERR_PERIOD = 0
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  input  logic        err_en,
  output logic        sym_stb,
  output logic        bit_stb,
  output logic        prbs_en,
  output logic [1:0]  bit_sel,
  output logic        pre_bit,
  output logic        tx_en,
  output logic        has_error,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state
);

  localparam logic [BITCNT_W-1:0] LAST_PRE   = last_idx(PRE_LEN);
  localparam logic [BITCNT_W-1:0] LAST_PAY   = last_idx(PAY_LEN);
  localparam logic [BITCNT_W-1:0] LAST_TAIL  = last_idx(TAIL_LEN);
  localparam logic [BITCNT_W-1:0] LAST_DRAIN = last_idx(DRAIN_LEN);
  localparam logic [BITCNT_W-1:0] LAST_GAP   = last_idx(GAP_LEN);
  localparam logic [BITCNT_W-1:0] LAST_ERR   = last_idx(ERR_PERIOD);

  state_t              state_q, state_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [BITCNT_W-1:0] errcnt_q, errcnt_d;
  logic                start_pend_q, start_pend_d;
  logic                aborted_q, aborted_d;
  logic                tx_en_q, tx_en_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_cnt_q;
  logic                cnt_inc;
  logic [3:0]          pre_idx;

  tx_strobe_gen #(.DIV(DIV)) u_strobe (
    .sys_clk (sys_clk),
    .reset   (reset),
    .sym_stb (sym_stb),
    .bit_stb (bit_stb)
  );

  // Next-state logic: every transition and counter step waits for bit_stb.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    errcnt_d     = errcnt_q;
    start_pend_d = start_pend_q;
    aborted_d    = aborted_q;
    frame_done_d = 1'b0;
    cnt_inc      = 1'b0;

    // A start request is only remembered while idle.
    if (state_q == IDLE && start) start_pend_d = 1'b1;

    if (bit_stb) begin
      bitcnt_d = bitcnt_q + BITCNT_W'(1);
      unique case (state_q)
        IDLE: begin
          // abort on the deciding strobe cancels a pending start
          if (abort) start_pend_d = 1'b0;
          else if (start_pend_q) begin
            start_pend_d = 1'b0;
            state_d      = PRE;
          end
        end
        PRE: begin
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = TAIL;
          end else if (bitcnt_q == LAST_PRE) begin
            state_d = PAY;
          end
        end
        PAY: begin
          errcnt_d = (errcnt_q == LAST_ERR) ? '0 : errcnt_q + BITCNT_W'(1);
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = TAIL;
          end else if (bitcnt_q == LAST_PAY) begin
            state_d = TAIL;
          end
        end
        TAIL:  if (bitcnt_q == LAST_TAIL)  state_d = DRAIN;
        DRAIN: if (bitcnt_q == LAST_DRAIN) state_d = GAP;
        GAP: begin
          if (bitcnt_q == LAST_GAP) begin
            frame_done_d = 1'b1;
            cnt_inc      = ~aborted_q;
            aborted_d    = 1'b0;
            state_d      = continuous ? PRE : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      // each state starts counting its bits from zero
      if (state_d != state_q) bitcnt_d = '0;
      if (state_d == PAY && state_q != PAY) errcnt_d = '0;
    end

    tx_en_d = (state_d == PRE) || (state_d == PAY) ||
              (state_d == TAIL) || (state_d == DRAIN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      errcnt_q     <= '0;
      start_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      errcnt_q     <= errcnt_d;
      start_pend_q <= start_pend_d;
      aborted_q    <= aborted_d;
      tx_en_q      <= tx_en_d;
      frame_done_q <= frame_done_d;
      if (cnt_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Encoder input select and preamble bit, decoded from the current state.
  always_comb begin
    bit_sel = SEL_ZERO;
    pre_bit = 1'b0;
    if (state_q == PRE) begin
      bit_sel = SEL_PRE;
      pre_bit = PRE_WORD[pre_idx];
    end else if (state_q == PAY) begin
      bit_sel = SEL_PRBS;
    end
  end

  assign pre_idx    = 4'd15 - bitcnt_q[3:0];
  assign prbs_en    = bit_stb && (state_q == PAY);
  assign has_error  = err_en && (ERR_PERIOD != 0) && (state_q == PAY) &&
                      (errcnt_q == LAST_ERR);
  assign tx_en      = tx_en_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl: an expected per-bit-period trace of
// each frame is generated from segment lengths and compared twice per period.
module tb_tx_frame_ctrl;

  localparam int DIV        = 4;
  localparam int PRE_LEN    = 16;
  localparam int PAY_LEN    = 64;
  localparam int TAIL_LEN   = 2;
  localparam int DRAIN_LEN  = 2;
  localparam int GAP_LEN    = 8;
  localparam int ERR_PERIOD = 16;
  localparam int BIT_CYC    = 2 * DIV;
  localparam int FRAME_BITS = PRE_LEN + PAY_LEN + TAIL_LEN + DRAIN_LEN + GAP_LEN;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic        err_en = 1'b0;
  logic        sym_stb, bit_stb, prbs_en, pre_bit, tx_en, has_error, busy, frame_done;
  logic [1:0]  bit_sel;
  logic [15:0] frame_cnt;
  logic [2:0]  state;
  logic [9:0]  obs;

  tx_frame_ctrl #(.ERR_PERIOD(ERR_PERIOD)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .err_en     (err_en),
    .sym_stb    (sym_stb),
    .bit_stb    (bit_stb),
    .prbs_en    (prbs_en),
    .bit_sel    (bit_sel),
    .pre_bit    (pre_bit),
    .tx_en      (tx_en),
    .has_error  (has_error),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .state      (state)
  );

  // clock
  always #5 sys_clk = ~sys_clk;

  // packed view: {state, bit_sel, pre_bit, tx_en, has_error, busy, prbs_en}
  assign obs = {state, bit_sel, pre_bit, tx_en, has_error, busy, prbs_en};

  int n_cmp = 0;
  int n_fail = 0;
  int tx_hi = 0;
  int fd_pulses = 0;
  int fc_model = 0;
  int fd_model = 0;
  int exp_err = 0;
  logic [9:0] exp_q[$];
  int         mark_q[$];  // 0 none, 1 counted frame ends, 2 aborted frame ends

  // background tallies of tx_en-high cycles and frame_done pulses
  always @(negedge sys_clk) begin
    if (tx_en === 1'b1) tx_hi++;
    if (frame_done === 1'b1) fd_pulses++;
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [9:0] mk(input logic [2:0] st, input logic [1:0] sel,
                                    input logic pre, input logic tx, input logic er,
                                    input logic prbs);
    return {st, sel, pre, tx, er, (st != 3'd0), prbs};
  endfunction

  task automatic push(input logic [9:0] r, input int m);
    exp_q.push_back(r);
    mark_q.push_back(m);
  endtask

  // Expected trace: idle_lead+1 idle periods, nfr frames, one trailing idle.
  task automatic build(input int nfr, input logic err, input int abort_bit, input int idle_lead);
    logic [15:0] pw;
    int          npay;
    logic        ab;
    logic        e;
    pw = 16'hF35A;
    exp_q.delete();
    mark_q.delete();
    exp_err = 0;
    for (int i = 0; i <= idle_lead; i++) push(mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
    for (int f = 0; f < nfr; f++) begin
      ab   = (f == 0) && (abort_bit >= 0);
      npay = ab ? abort_bit + 1 : PAY_LEN;
      for (int i = 0; i < PRE_LEN; i++) push(mk(3'd1, 2'd1, pw[15-i], 1'b1, 1'b0, 1'b0), 0);
      for (int i = 0; i < npay; i++) begin
        e = err && ((i % ERR_PERIOD) == ERR_PERIOD - 1);
        if (e) exp_err++;
        push(mk(3'd2, 2'd2, 1'b0, 1'b1, e, 1'b1), 0);
      end
      for (int i = 0; i < TAIL_LEN; i++)  push(mk(3'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), 0);
      for (int i = 0; i < DRAIN_LEN; i++) push(mk(3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), 0);
      for (int i = 0; i < GAP_LEN; i++)
        push(mk(3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), (i == GAP_LEN - 1) ? (ab ? 2 : 1) : 0);
    end
    push(mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
  endtask

  // Advance to the next negedge at which bit_stb is high, with a cycle budget.
  task automatic wait_bit(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 4 * BIT_CYC; k++) begin
      if (bit_stb === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $error("FAIL bit_stb_timeout observed=none expected=strobe");
    end
  endtask

  // Entered at the first cycle of a bit period; drives and checks each period.
  task automatic run(input int start_idx, input int abort_idx, input logic cont,
                     input int cont_clear_idx, input int stop_after);
    logic [9:0] r;
    int         m;
    int         j;
    int         err_seen;
    logic       ok;
    j = 0;
    err_seen = 0;
    continuous = cont;
    while (exp_q.size() > 0 && j != stop_after) begin
      r = exp_q.pop_front();
      m = mark_q.pop_front();
      if (j == start_idx) start = 1'b1;
      if (j == abort_idx) abort = 1'b1;
      if (j == cont_clear_idx) continuous = 1'b0;
      check($sformatf("bit%0d_first_cycle", j), 16'(obs), 16'(r & 10'h3FE));
      @(negedge sys_clk);
      start = 1'b0;
      wait_bit(ok);
      if (!ok) return;
      check($sformatf("bit%0d_strobe_cycle", j), 16'(obs), 16'(r));
      if (obs[2] === 1'b1) err_seen++;
      @(negedge sys_clk);
      abort = 1'b0;
      if (m != 0) begin
        fd_model++;
        if (m == 1) fc_model++;
        check("frame_done", 16'(frame_done), 16'd1);
        check("frame_cnt", frame_cnt, 16'(fc_model));
      end
      j++;
    end
    if (stop_after < 0) check("has_error_periods", 16'(err_seen), 16'(exp_err));
  endtask

  initial begin
    int   cyc;
    int   first_sym;
    int   tx_base;
    int   lead;
    int   ab;
    logic e;
    logic ok;

    // reset: every output low
    repeat (4) @(negedge sys_clk);
    check("reset_outputs", {5'd0, sym_stb, bit_stb, prbs_en, bit_sel, pre_bit, tx_en,
                            has_error, busy, frame_done, state}, 16'd0);
    check("reset_frame_cnt", frame_cnt, 16'd0);

    // strobe phase after reset release
    reset = 1'b0;
    cyc = 0;
    first_sym = -1;
    while (cyc < 40 && bit_stb !== 1'b1) begin
      if (sym_stb === 1'b1 && first_sym < 0) first_sym = cyc;
      @(negedge sys_clk);
      cyc++;
    end
    check("first_sym_stb_cycle", 16'(first_sym), 16'(DIV - 1));
    check("first_bit_stb_cycle", 16'(cyc), 16'(2 * DIV - 1));
    @(negedge sys_clk);

    // default frame, no error injection; tx_en length in cycles
    err_en = 1'b0;
    build(1, 1'b0, -1, 1);
    tx_base = tx_hi;
    run(1, -1, 1'b0, -1, -1);
    check("tx_en_cycles", 16'(tx_hi - tx_base), 16'(84 * BIT_CYC));

    // error injection every 16th payload bit
    err_en = 1'b1;
    build(1, 1'b1, -1, 0);
    run(0, -1, 1'b0, -1, -1);

    // abort at payload bit 10
    err_en = 1'b0;
    build(1, 1'b0, 10, 0);
    run(0, 1 + PRE_LEN + 10, 1'b0, -1, -1);

    // abort and start together while idle
    build(0, 1'b0, -1, 0);
    run(0, 0, 1'b0, -1, -1);
    check("cnt_after_idle_abort", frame_cnt, 16'(fc_model));

    // three back-to-back frames
    e = 1'($urandom_range(0, 1));
    err_en = e;
    build(3, e, -1, 0);
    run(0, -1, 1'b1, 1 + 2 * FRAME_BITS, -1);

    // randomized single frames
    for (int it = 0; it < 4; it++) begin
      e    = 1'($urandom_range(0, 1));
      lead = int'($urandom_range(0, 3));
      ab   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PAY_LEN - 1)) : -1;
      err_en = e;
      build(1, e, ab, lead);
      run(lead, (ab >= 0) ? lead + 1 + PRE_LEN + ab : -1, 1'b0, -1, -1);
    end

    // reset in the middle of the payload
    err_en = 1'b0;
    build(1, 1'b0, -1, 0);
    run(0, -1, 1'b0, -1, 1 + PRE_LEN + 20);
    repeat (3) @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    check("midreset_state", 16'(state), 16'd0);
    check("midreset_tx_en", 16'(tx_en), 16'd0);
    check("midreset_busy", 16'(busy), 16'd0);
    check("midreset_frame_cnt", frame_cnt, 16'd0);
    fc_model = 0;
    @(negedge sys_clk);
    reset = 1'b0;
    wait_bit(ok);
    @(negedge sys_clk);
    build(1, 1'b0, -1, 0);
    run(0, -1, 1'b0, -1, -1);

    check("frame_done_pulses", 16'(fd_pulses), 16'(fd_model));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
